// File: rtl/inst_rom_resp.sv
// Boot-loadable instruction ROM responder with 1-cycle fetch latency.
// Optional macro INST_ROM_FETCH_CNT_EN adds a successful-fetch counter.
module inst_rom_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        inst_err,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        reload,
`ifdef INST_ROM_FETCH_CNT_EN
    output logic [31:0] fetch_cnt,
`endif
    output logic        boot_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] LAST_IDX = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [PW-1:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   mem [DEPTH];

    logic          load_fire;
    logic          fetch;
    logic          bad;
    logic [29:0]   idx;
    logic [29:0]   words_loaded;

    assign load_ready   = (state == LOAD);
    assign boot_done    = (state == RUN);
    // wr_ptr doubles as the loaded-word count; widened for a full 30-bit compare
    assign words_loaded = {{(30 - PW){1'b0}}, wr_ptr};
    assign idx          = addr[31:2];
    assign bad          = (addr[1:0] != 2'b00) || (idx >= words_loaded);

    always_comb begin
        state_nxt = state;
        load_fire = 1'b0;
        fetch     = 1'b0;
        unique case (state)
            LOAD: begin
                load_fire = load_valid;
                if (load_valid && (load_last || wr_ptr == LAST_IDX))
                    state_nxt = RUN;
            end
            RUN: begin
                fetch = ce && !reload;
                if (reload)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && reload)
                wr_ptr <= '0;
            else if (load_fire)
                wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && load_fire)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
            inst_err   <= 1'b0;
        end else begin
            inst_valid <= fetch;
            inst_err   <= fetch && bad;
            if (fetch && !bad)
                inst <= mem[idx[DEPTH_LOG2-1:0]];
            else
                inst <= NOP_WORD;
        end
    end

`ifdef INST_ROM_FETCH_CNT_EN
    // counts in step with the good result becoming visible
    always_ff @(posedge clk) begin
        if (rst)
            fetch_cnt <= '0;
        else if (state == RUN && reload)
            fetch_cnt <= '0;
        else if (fetch && !bad)
            fetch_cnt <= fetch_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_inst_rom_resp.sv
// Randomized self-checking bench for inst_rom_resp against an
// array-based reference model.
module tb_inst_rom_resp;

    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk = 0;
    logic        rst, ce, load_valid, load_last, reload;
    logic [31:0] addr, load_data;
    logic [31:0] inst;
    logic        inst_valid, inst_err, load_ready, boot_done;
`ifdef INST_ROM_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    inst_rom_resp dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_err   (inst_err),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .reload     (reload),
`ifdef INST_ROM_FETCH_CNT_EN
        .fetch_cnt  (fetch_cnt),
`endif
        .boot_done  (boot_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    logic [31:0] m_mem [DEPTH];
    int          m_words = 0;
    bit          m_run = 0;
    logic [31:0] e_inst = NOP;
    bit          e_valid = 0, e_err = 0;
    logic [31:0] e_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit c, input logic [31:0] a,
                       input bit lv, input logic [31:0] ld,
                       input bit ll, input bit rl);
        int unsigned wi;
        rst = r; ce = c; addr = a;
        load_valid = lv; load_data = ld; load_last = ll; reload = rl;
        @(posedge clk);
        e_valid = 0; e_err = 0; e_inst = NOP;
        if (r) begin
            m_run = 0; m_words = 0; e_cnt = 0;
        end else if (!m_run) begin
            if (lv) begin
                m_mem[m_words] = ld;
                m_words++;
                if (ll || m_words == DEPTH) m_run = 1;
            end
        end else if (rl) begin
            m_run = 0; m_words = 0; e_cnt = 0;
        end else if (c) begin
            e_valid = 1;
            wi = a / 4;
            if (a % 4 != 0 || wi >= m_words) begin
                e_err = 1;
            end else begin
                e_inst = m_mem[wi];
                e_cnt++;
            end
        end
        #1;
        check("inst", inst, e_inst);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
        check("inst_err", {31'd0, inst_err}, {31'd0, e_err});
        check("load_ready", {31'd0, load_ready}, {31'd0, !m_run});
        check("boot_done", {31'd0, boot_done}, {31'd0, m_run});
`ifdef INST_ROM_FETCH_CNT_EN
        check("fetch_cnt", fetch_cnt, e_cnt);
`endif
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic ld(input logic [31:0] d, input bit last);
        cyc(0, 0, 0, 1, d, last, 0);
    endtask

    initial begin
        logic [31:0] a;
        int unsigned p;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 32'h5, 1, 0);
        // directed image load and fetches
        ld(32'h11, 0); ld(32'h22, 0); ld(32'h33, 0); ld(32'h44, 1);
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        fetch(32'h6); fetch(32'h10); fetch(32'h1000);
        idle();
        cyc(0, 1, 32'h0, 0, 0, 0, 1);
        cyc(0, 1, 32'h0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0, 0, 0, 0, 1);
        ld(32'hAA, 1);
        fetch(32'h0); fetch(32'h4);
        // reset mid-load
        cyc(0, 0, 0, 0, 0, 0, 1);
        ld(32'h1, 0); ld(32'h2, 0);
        cyc(1, 0, 0, 1, 32'h3, 0, 0);
        // fill whole memory without load_last
        for (int i = 0; i < DEPTH; i++)
            cyc(0, $urandom_range(0, 1), 0, 1, $urandom, 0, 0);
        fetch(32'hFFC); fetch(32'h0); fetch(32'h1000); fetch(32'hFFE);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            p = $urandom_range(0, 99);
            if (p < 3)
                a = $urandom;
            else if (p < 10)
                a = $urandom_range(0, 2 * DEPTH);
            else
                a = {$urandom_range(0, 40), 2'b00};
            cyc(p == 99, $urandom_range(0, 3) != 0, a,
                $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 15) == 0, $urandom_range(0, 60) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
